// File: rtl/tcp_segment_builder.sv
// Buffered TCP transmit encoder: latches header fields, buffers payload words while
// summing the checksum, then streams header, options and payload under valid/ready.
module tcp_segment_builder #(
   parameter int MAX_WORDS = 64,
   parameter int OPT_MAX   = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           src_ip,
   input  logic [31:0]           dest_ip,
   input  logic [15:0]           src_port,
   input  logic [15:0]           dest_port,
   input  logic [31:0]           seq_num,
   input  logic [31:0]           ack_num,
   input  logic [5:0]            flags,
   input  logic [15:0]           window,
   input  logic [15:0]           urg_ptr,
   input  logic [32*OPT_MAX-1:0] opt_words,
   input  logic [3:0]            opt_len,
   input  logic                  start,
   input  logic [15:0]           len_in,
   input  logic [31:0]           data,
   input  logic                  data_av,
   input  logic                  out_ready,
   output logic [31:0]           pkg_data,
   output logic                  wr_en,
   output logic                  fin,
   output logic [15:0]           checksum_out,
   output logic [15:0]           len_out,
   output logic                  busy,
   output logic                  err
);

   localparam int WCW = $clog2(MAX_WORDS + 1);
   localparam int AW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int CW  = (WCW > 4) ? WCW : 4;
   localparam logic [WCW-1:0] W1 = 1;
   localparam logic [CW-1:0]  C1 = 1;

   typedef enum logic [2:0] {IDLE, LOAD, FOLD, HDR, OPT, PAY} state_t;

   state_t state, state_nx;

   logic [31:0]              word0_r, seq_r, ack_r, hdr3_r;
   logic [15:0]              urg_r;
   logic [1:0]               len_rem_r;
   logic [3:0]               opt_len_r;
   logic [OPT_MAX-1:0][31:0] opt_r;
   logic [WCW-1:0]           nwords_r, wcnt;
   logic [CW-1:0]            ocnt;
   logic [31:0]              acc;
   logic [31:0]              pay_mem [MAX_WORDS];

   function automatic logic [31:0] halves(input logic [31:0] w);
      return {16'h0, w[31:16]} + {16'h0, w[15:0]};
   endfunction

   // Keeps only the bytes of the final word that fall inside len_in.
   function automatic logic [31:0] tail_mask(input logic [1:0] rem, input logic last);
      logic [31:0] m;
      m = '1;
      if (last) begin
         case (rem)
            2'd1:    m = 32'hff00_0000;
            2'd2:    m = 32'hffff_0000;
            2'd3:    m = 32'hffff_ff00;
            default: m = '1;
         endcase
      end
      return m;
   endfunction

   logic [16:0] nwords_in;
   logic        bad_start, accept, take0;
   logic [15:0] len_calc;
   logic [31:0] hdr3_in, word0_in, start_sum;

   always_comb begin
      nwords_in = ({1'b0, len_in} + 17'd3) >> 2;
      bad_start = (len_in > 16'(4 * MAX_WORDS)) || (opt_len > 4'(OPT_MAX));
      accept    = (state == IDLE) && start && !bad_start;
      len_calc  = 16'd20 + {10'd0, opt_len, 2'b00} + len_in;
      hdr3_in   = {4'd5 + opt_len, 6'd0, flags, window};
      word0_in  = data & tail_mask(len_in[1:0], nwords_in == 17'd1);
      take0     = data_av && (nwords_in != 17'd0);
      start_sum = halves(src_ip) + halves(dest_ip) + 32'h6 + {16'h0, len_calc}
                + halves({src_port, dest_port}) + halves(seq_num) + halves(ack_num)
                + halves(hdr3_in) + {16'h0, urg_ptr};
      for (int k = 0; k < OPT_MAX; k++)
         if (k < int'(opt_len)) start_sum = start_sum + halves(opt_words[32*k +: 32]);
      if (take0) start_sum = start_sum + halves(word0_in);
   end

   logic        ld_take, ld_last;
   logic [31:0] ld_word;
   logic [16:0] fold1, fold2;

   always_comb begin
      ld_take = (state == LOAD) && data_av;
      ld_last = (wcnt + W1) == nwords_r;
      ld_word = data & tail_mask(len_rem_r, ld_last);
      fold1   = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
      fold2   = {16'h0, fold1[16]} + {1'b0, fold1[15:0]};
   end

   logic hdr_end, opt_end, pay_end;

   always_comb begin
      hdr_end = ocnt == CW'(4);
      opt_end = (ocnt + C1) == CW'(opt_len_r);
      pay_end = (ocnt + C1) == CW'(nwords_r);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      fin      = 1'b0;
      pkg_data = 32'h0;
      busy     = (state != IDLE);
      case (state)
         IDLE: if (accept)
                  state_nx = (nwords_in == 17'd0 || (take0 && nwords_in == 17'd1)) ? FOLD : LOAD;
         LOAD: if (ld_take && ld_last) state_nx = FOLD;
         FOLD: state_nx = HDR;
         HDR: begin
            wr_en = 1'b1;
            fin   = hdr_end && (opt_len_r == 4'd0) && (nwords_r == '0);
            case (ocnt)
               CW'(0):  pkg_data = word0_r;
               CW'(1):  pkg_data = seq_r;
               CW'(2):  pkg_data = ack_r;
               CW'(3):  pkg_data = hdr3_r;
               default: pkg_data = {checksum_out, urg_r};
            endcase
            if (out_ready && hdr_end)
               state_nx = (opt_len_r != 4'd0) ? OPT : (nwords_r != '0) ? PAY : IDLE;
         end
         OPT: begin
            wr_en = 1'b1;
            fin   = opt_end && (nwords_r == '0);
            for (int k = 0; k < OPT_MAX; k++)
               if (ocnt == CW'(k)) pkg_data = opt_r[k];
            if (out_ready && opt_end) state_nx = (nwords_r != '0) ? PAY : IDLE;
         end
         PAY: begin
            wr_en    = 1'b1;
            fin      = pay_end;
            pkg_data = pay_mem[AW'(ocnt)];
            if (out_ready && pay_end) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err          <= 1'b0;
         word0_r      <= '0;
         seq_r        <= '0;
         ack_r        <= '0;
         hdr3_r       <= '0;
         urg_r        <= '0;
         len_rem_r    <= '0;
         opt_len_r    <= '0;
         opt_r        <= '0;
         nwords_r     <= '0;
         wcnt         <= '0;
         ocnt         <= '0;
         acc          <= '0;
         checksum_out <= '0;
         len_out      <= '0;
      end else begin
         err <= (state == IDLE) && start && bad_start;
         if (accept) begin
            word0_r   <= {src_port, dest_port};
            seq_r     <= seq_num;
            ack_r     <= ack_num;
            hdr3_r    <= hdr3_in;
            urg_r     <= urg_ptr;
            len_rem_r <= len_in[1:0];
            opt_len_r <= opt_len;
            opt_r     <= opt_words;
            nwords_r  <= WCW'(nwords_in);
            len_out   <= len_calc;
            acc       <= start_sum;
            wcnt      <= take0 ? W1 : '0;
         end
         if (ld_take) begin
            acc  <= acc + halves(ld_word);
            wcnt <= wcnt + W1;
         end
         // Second fold cannot carry again, so a zero result is sent as zero.
         if (state == FOLD) checksum_out <= ~fold2[15:0];
         if (state != state_nx)       ocnt <= '0;
         else if (wr_en && out_ready) ocnt <= ocnt + C1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && take0) pay_mem[0] <= word0_in;
      if (ld_take)         pay_mem[AW'(wcnt)] <= ld_word;
   end

endmodule

// File: tb/tb_tcp_segment_builder.sv
// Directed vector bench for tcp_segment_builder: table of segments plus reject/reset sequences.
module tb_tcp_segment_builder;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       src_ip, dest_ip, seq_num, ack_num, data;
   logic [15:0]       src_port, dest_port, window, urg_ptr, len_in;
   logic [5:0]        flags;
   logic [32*10-1:0]  opt_words;
   logic [3:0]        opt_len;
   logic              start, data_av, out_ready;
   logic [31:0]       pkg_data;
   logic              wr_en, fin, busy, err;
   logic [15:0]       checksum_out, len_out;

   tcp_segment_builder #(.MAX_WORDS(64), .OPT_MAX(10)) dut (
      .clk(clk), .reset(reset), .src_ip(src_ip), .dest_ip(dest_ip),
      .src_port(src_port), .dest_port(dest_port), .seq_num(seq_num), .ack_num(ack_num),
      .flags(flags), .window(window), .urg_ptr(urg_ptr), .opt_words(opt_words),
      .opt_len(opt_len), .start(start), .len_in(len_in), .data(data), .data_av(data_av),
      .out_ready(out_ready), .pkg_data(pkg_data), .wr_en(wr_en), .fin(fin),
      .checksum_out(checksum_out), .len_out(len_out), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic [15:0]      len;
      logic [3:0]       olen;
      logic [31:0]      opt0;
      int               gap;
      int               stall_at;
      int               stall_n;
      int               nexp;
      logic [0:8][31:0] exp;
      logic [15:0]      csum;
      logic [15:0]      lout;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] payload [3];
   int          n_pass = 0;
   int          n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tot++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, got, want);
   endtask

   task automatic run_vec(input vec_t v);
      int nw, feed, got, cyc, stalls;
      nw = (int'(v.len) + 3) / 4;
      @(negedge clk);
      len_in  = v.len;
      opt_len = v.olen;
      for (int k = 0; k < 10; k++) opt_words[32*k +: 32] = (k == 0) ? v.opt0 : 32'hcafef00d;
      start   = 1'b1;
      data_av = 1'b1;
      data    = payload[0];
      feed    = (nw > 0) ? 1 : 0;
      got = 0; cyc = 0; stalls = 0;
      while (got < v.nexp && cyc < 100) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (v.gap != 0 && cyc == 1) data_av = 1'b0;
         else begin
            data_av = 1'b1;
            if (feed < nw) begin
               data = payload[feed];
               feed++;
            end else data = 32'hdeadbeef;
         end
         if (wr_en && got == v.stall_at && stalls < v.stall_n) begin
            out_ready = 1'b0;
            stalls++;
            #1;
            chk({v.name, " hold word"}, pkg_data, v.exp[got]);
            chk({v.name, " hold fin"}, 32'(fin), 32'(got == v.nexp - 1));
         end else begin
            out_ready = 1'b1;
            #1;
            if (wr_en) begin
               chk($sformatf("%s word%0d", v.name, got), pkg_data, v.exp[got]);
               chk($sformatf("%s fin%0d", v.name, got), 32'(fin), 32'(got == v.nexp - 1));
               got++;
            end
         end
      end
      chk({v.name, " word count"}, 32'(got), 32'(v.nexp));
      @(negedge clk);
      data_av   = 1'b0;
      out_ready = 1'b1;
      chk({v.name, " idle wr_en"}, 32'(wr_en), 32'd0);
      chk({v.name, " idle pkg_data"}, pkg_data, 32'd0);
      chk({v.name, " idle busy"}, 32'(busy), 32'd0);
      chk({v.name, " checksum"}, 32'(checksum_out), 32'(v.csum));
      chk({v.name, " len_out"}, 32'(len_out), 32'(v.lout));
   endtask

   initial begin
      payload[0] = 32'h48656c6c;
      payload[1] = 32'h6f20576f;
      payload[2] = 32'h726c64ee;   // trailing byte lies past len_in and must be zeroed
      vecs[0] = '{"t1", 16'd11, 4'd0, 32'h0, 0, -1, 0, 8,
                  {32'ha08f2694, 32'h1, 32'h2, 32'h503f0003, 32'h969f0004,
                   32'h48656c6c, 32'h6f20576f, 32'h726c6400, 32'h0}, 16'h969f, 16'h001f};
      vecs[1] = '{"t2", 16'd11, 4'd1, 32'h020405b4, 0, -1, 0, 9,
                  {32'ha08f2694, 32'h1, 32'h2, 32'h603f0003, 32'h7ee30004,
                   32'h020405b4, 32'h48656c6c, 32'h6f20576f, 32'h726c6400}, 16'h7ee3, 16'h0023};
      vecs[2] = vecs[0];
      vecs[2].name = "t3stall"; vecs[2].stall_at = 6; vecs[2].stall_n = 3;
      vecs[3] = vecs[0];
      vecs[3].name = "t1gap"; vecs[3].gap = 1;
      vecs[4] = '{"len5", 16'd5, 4'd0, 32'h0, 0, -1, 0, 7,
                  {32'ha08f2694, 32'h1, 32'h2, 32'h503f0003, 32'hc4a10004,
                   32'h48656c6c, 32'h6f000000, 32'h0, 32'h0}, 16'hc4a1, 16'h0019};
      vecs[5] = '{"t6", 16'd0, 4'd0, 32'h0, 0, -1, 0, 5,
                  {32'ha08f2694, 32'h1, 32'h2, 32'h503f0003, 32'he8780004,
                   32'h0, 32'h0, 32'h0, 32'h0}, 16'he878, 16'h0014};

      reset = 1'b1; src_ip = 0; dest_ip = 0; src_port = 16'ha08f; dest_port = 16'h2694;
      seq_num = 32'h1; ack_num = 32'h2; flags = 6'h3f; window = 16'h3; urg_ptr = 16'h4;
      opt_words = '0; opt_len = 0; start = 0; len_in = 0; data = 0; data_av = 0;
      out_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("reset wr_en", 32'(wr_en), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset len_out", 32'(len_out), 32'd0);
      chk("reset checksum", 32'(checksum_out), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Oversized payload and oversized option count are both rejected.
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         len_in  = (r == 0) ? 16'd257 : 16'd4;
         opt_len = (r == 0) ? 4'd0 : 4'd11;
         start   = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("reject err", 32'(err), 32'd1);
         chk("reject busy", 32'(busy), 32'd0);
         chk("reject wr_en", 32'(wr_en), 32'd0);
         @(negedge clk);
         chk("reject err pulse", 32'(err), 32'd0);
         chk("reject still idle", 32'(busy), 32'd0);
      end
      run_vec(vecs[0]);

      // Reset in LOAD aborts the segment outright.
      @(negedge clk);
      len_in = 16'd11; opt_len = 0; start = 1'b1; data_av = 1'b1; data = payload[0];
      @(negedge clk);
      start = 1'b0; data = payload[1];
      chk("load busy", 32'(busy), 32'd1);
      chk("load len_out", 32'(len_out), 32'h001f);
      reset = 1'b1;
      #1;
      chk("abort wr_en", 32'(wr_en), 32'd0);
      chk("abort pkg_data", pkg_data, 32'd0);
      chk("abort fin", 32'(fin), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort len_out", 32'(len_out), 32'd0);
      chk("abort checksum", 32'(checksum_out), 32'd0);
      @(negedge clk);
      reset = 1'b0; data_av = 1'b0;
      run_vec(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
